// File: rtl/fadd_result_fifo.sv
// Result FIFO between the FP adder and writeback, first-word-fall-through from storage.
// Define FADD_FFLAGS_ACCRUE_EN to enable accrued exception-flag collection on pops.
module fadd_result_fifo #(
   parameter int EXPWIDTH     = 5,
   parameter int PRECISION    = 3,
   parameter int CTRL_C_WIDTH = 16,
   parameter int DEPTH_WARP   = 4,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 in_valid_i,
   output logic                                 in_ready_o,
   input  logic [EXPWIDTH+PRECISION:0]          result_i,
   input  logic [4:0]                           fflags_i,
   input  logic [CTRL_C_WIDTH-1:0]              ctrl_c_i,
   input  logic [2:0]                           ctrl_rm_i,
   input  logic [7:0]                           ctrl_reg_idxw_i,
   input  logic [DEPTH_WARP-1:0]                ctrl_warpid_i,
   output logic                                 out_valid_o,
   input  logic                                 out_ready_i,
   output logic [EXPWIDTH+PRECISION:0]          result_o,
   output logic [4:0]                           fflags_o,
   output logic [CTRL_C_WIDTH-1:0]              ctrl_c_o,
   output logic [2:0]                           ctrl_rm_o,
   output logic [7:0]                           ctrl_reg_idxw_o,
   output logic [DEPTH_WARP-1:0]                ctrl_warpid_o,
   output logic [$clog2(FIFO_DEPTH):0]          count_o,
   input  logic                                 acc_clr_i,
   output logic [4:0]                           acc_fflags_o
);

   localparam int RES_W = EXPWIDTH + PRECISION + 1;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CNT_W = AW + 1;

   typedef struct packed {
      logic [RES_W-1:0]        result;
      logic [4:0]              fflags;
      logic [CTRL_C_WIDTH-1:0] ctrl_c;
      logic [2:0]              ctrl_rm;
      logic [7:0]              ctrl_reg_idxw;
      logic [DEPTH_WARP-1:0]   ctrl_warpid;
   } entry_t;

   entry_t           r_mem [FIFO_DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;
   entry_t           w_in;
   entry_t           w_head;

   // Ready/valid depend only on registered occupancy, so no comb path crosses the FIFO.
   assign in_ready_o  = (r_count != CNT_W'(FIFO_DEPTH));
   assign out_valid_o = (r_count != '0);
   assign w_push      = in_valid_i & in_ready_o;
   assign w_pop       = out_valid_o & out_ready_i;

   assign w_in = '{result:        result_i,
                   fflags:        fflags_i,
                   ctrl_c:        ctrl_c_i,
                   ctrl_rm:       ctrl_rm_i,
                   ctrl_reg_idxw: ctrl_reg_idxw_i,
                   ctrl_warpid:   ctrl_warpid_i};

   // NOTE: storage is reset too, so the head fields read as zero straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      end else if (w_push) begin
         // NOTE: non-blocking assignments keep every register update ordered to the edge.
         r_mem[r_wr_ptr] <= w_in;
      end
   end

   // Pointers wrap naturally because FIFO_DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
         else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      end
   end

   assign w_head          = r_mem[r_rd_ptr];
   assign result_o        = w_head.result;
   assign fflags_o        = w_head.fflags;
   assign ctrl_c_o        = w_head.ctrl_c;
   assign ctrl_rm_o       = w_head.ctrl_rm;
   assign ctrl_reg_idxw_o = w_head.ctrl_reg_idxw;
   assign ctrl_warpid_o   = w_head.ctrl_warpid;
   assign count_o         = r_count;

`ifdef FADD_FFLAGS_ACCRUE_EN
   logic [4:0] r_acc;

   // Clear applies to the old value only, so flags popped during a clear survive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_acc <= '0;
      else        r_acc <= (acc_clr_i ? 5'd0 : r_acc) | (w_pop ? w_head.fflags : 5'd0);
   end

   assign acc_fflags_o = r_acc;
`else
   logic w_unused_acc_clr;

   assign w_unused_acc_clr = acc_clr_i;
   assign acc_fflags_o     = '0;
`endif

endmodule

// File: tb/tb_fadd_result_fifo.sv
// Randomized self-checking bench for fadd_result_fifo against a queue-based reference model.
// Accrued-flag expectations follow FADD_FFLAGS_ACCRUE_EN when it is defined for the build.
module tb_fadd_result_fifo;

   localparam int EW    = 5;
   localparam int PR    = 3;
   localparam int CW    = 16;
   localparam int DW    = 4;
   localparam int FD    = 4;
   localparam int RW    = EW + PR + 1;
   localparam int CNTW  = $clog2(FD) + 1;

   typedef struct packed {
      logic [RW-1:0] res;
      logic [4:0]    ff;
      logic [CW-1:0] c;
      logic [2:0]    rm;
      logic [7:0]    idx;
      logic [DW-1:0] warp;
   } entry_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid_i = 1'b0;
   logic            in_ready_o;
   logic [RW-1:0]   result_i = '0;
   logic [4:0]      fflags_i = '0;
   logic [CW-1:0]   ctrl_c_i = '0;
   logic [2:0]      ctrl_rm_i = '0;
   logic [7:0]      ctrl_reg_idxw_i = '0;
   logic [DW-1:0]   ctrl_warpid_i = '0;
   logic            out_valid_o;
   logic            out_ready_i = 1'b0;
   logic [RW-1:0]   result_o;
   logic [4:0]      fflags_o;
   logic [CW-1:0]   ctrl_c_o;
   logic [2:0]      ctrl_rm_o;
   logic [7:0]      ctrl_reg_idxw_o;
   logic [DW-1:0]   ctrl_warpid_o;
   logic [CNTW-1:0] count_o;
   logic            acc_clr_i = 1'b0;
   logic [4:0]      acc_fflags_o;

   entry_t     q[$];
   logic [4:0] m_acc = '0;
   int         checks = 0;
   int         errors = 0;

   fadd_result_fifo #(
      .EXPWIDTH(EW), .PRECISION(PR), .CTRL_C_WIDTH(CW), .DEPTH_WARP(DW), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .result_i(result_i), .fflags_i(fflags_i),
      .ctrl_c_i(ctrl_c_i), .ctrl_rm_i(ctrl_rm_i),
      .ctrl_reg_idxw_i(ctrl_reg_idxw_i), .ctrl_warpid_i(ctrl_warpid_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .result_o(result_o), .fflags_o(fflags_o),
      .ctrl_c_o(ctrl_c_o), .ctrl_rm_o(ctrl_rm_o),
      .ctrl_reg_idxw_o(ctrl_reg_idxw_o), .ctrl_warpid_o(ctrl_warpid_o),
      .count_o(count_o), .acc_clr_i(acc_clr_i), .acc_fflags_o(acc_fflags_o)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] exp_acc(input logic [4:0] when_enabled);
`ifdef FADD_FFLAGS_ACCRUE_EN
      return when_enabled;
`else
      return 5'd0;
`endif
   endfunction

   function automatic entry_t dut_head();
      return '{res: result_o, ff: fflags_o, c: ctrl_c_o, rm: ctrl_rm_o,
               idx: ctrl_reg_idxw_o, warp: ctrl_warpid_o};
   endfunction

   // Drives one cycle from a negedge, advances the model at the posedge, returns at the next negedge.
   task automatic drive_cycle(input bit v, input logic [RW-1:0] res, input logic [4:0] ff,
                              input bit rdy, input bit clr);
      entry_t e;
      bit     push;
      bit     pop;
      e.res  = res;
      e.ff   = ff;
      e.c    = CW'($urandom);
      e.rm   = 3'($urandom);
      e.idx  = 8'($urandom);
      e.warp = DW'($urandom);
      in_valid_i      = v;
      result_i        = e.res;
      fflags_i        = e.ff;
      ctrl_c_i        = e.c;
      ctrl_rm_i       = e.rm;
      ctrl_reg_idxw_i = e.idx;
      ctrl_warpid_i   = e.warp;
      out_ready_i     = rdy;
      acc_clr_i       = clr;
      push = v && (q.size() < FD);
      pop  = rdy && (q.size() > 0);
      @(posedge clk);
      m_acc = (clr ? 5'd0 : m_acc) | (pop ? q[0].ff : 5'd0);
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(e);
      @(negedge clk);
      in_valid_i  = 1'b0;
      out_ready_i = 1'b0;
      acc_clr_i   = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < FD + 1; i++) drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid_o); end
      checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", in_ready_o); end
      checks++; if (count_o !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", count_o); end
      checks++; if (dut_head() !== '0) begin errors++; $display("FAIL reset_data got %h want 0", dut_head()); end
      checks++; if (acc_fflags_o !== 5'd0) begin errors++; $display("FAIL reset_acc got %h want 0", acc_fflags_o); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      drive_cycle(1'b1, RW'(9'h03C), 5'h01, 1'b0, 1'b0);
      checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", out_valid_o); end
      checks++; if (result_o !== RW'(9'h03C)) begin errors++; $display("FAIL single_result got %h want 03c", result_o); end
      checks++; if (count_o !== CNTW'(1)) begin errors++; $display("FAIL single_count got %0d want 1", count_o); end
      checks++; if (dut_head() !== q[0]) begin errors++; $display("FAIL single_fields got %h want %h", dut_head(), q[0]); end
      drain();
      checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL single_drain got %0b want 0", out_valid_o); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < FD; i++) drive_cycle(1'b1, RW'(9'h011 + i), 5'($urandom), 1'b0, 1'b0);
      checks++; if (count_o !== CNTW'(FD)) begin errors++; $display("FAIL fill_count got %0d want %0d", count_o, FD); end
      checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL fill_ready got %0b want 0", in_ready_o); end
      drive_cycle(1'b1, RW'(9'h0AA), 5'h1F, 1'b0, 1'b0);
      checks++; if (count_o !== CNTW'(FD)) begin errors++; $display("FAIL fill_fifth_count got %0d want %0d", count_o, FD); end
      for (int i = 0; i < FD; i++) begin
         checks++;
         if (out_valid_o !== 1'b1 || result_o !== RW'(9'h011 + i)) begin
            errors++; $display("FAIL fill_order[%0d] got v=%0b %h want v=1 %h", i, out_valid_o, result_o, RW'(9'h011 + i));
         end
         drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
      end
      checks++; if (count_o !== '0) begin errors++; $display("FAIL fill_empty got %0d want 0", count_o); end
   endtask

   task automatic test_full_stream();
      for (int i = 0; i < FD; i++) drive_cycle(1'b1, RW'(9'h020 + i), 5'($urandom), 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (in_ready_o !== (q.size() < FD) || count_o !== CNTW'(q.size()) || dut_head() !== q[0]) begin
            errors++; $display("FAIL stream[%0d] got rdy=%0b cnt=%0d head=%h want rdy=%0b cnt=%0d head=%h",
                                k, in_ready_o, count_o, dut_head(), q.size() < FD, q.size(), q[0]);
         end
         drive_cycle(1'b1, RW'(9'h030 + k), 5'($urandom), 1'b1, 1'b0);
         if (k == 0) begin
            checks++; if (count_o !== CNTW'(FD - 1)) begin errors++; $display("FAIL stream_first_pop got %0d want %0d", count_o, FD - 1); end
         end
      end
      while (q.size() > 0) begin
         checks++;
         if (dut_head() !== q[0]) begin errors++; $display("FAIL stream_drain got %h want %h", dut_head(), q[0]); end
         drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_simul();
      drive_cycle(1'b1, RW'(9'h041), 5'($urandom), 1'b0, 1'b0);
      drive_cycle(1'b1, RW'(9'h042), 5'($urandom), 1'b0, 1'b0);
      drive_cycle(1'b1, RW'(9'h043), 5'($urandom), 1'b1, 1'b0);
      checks++; if (count_o !== CNTW'(2)) begin errors++; $display("FAIL simul_count got %0d want 2", count_o); end
      checks++; if (result_o !== RW'(9'h042)) begin errors++; $display("FAIL simul_head got %h want 042", result_o); end
      drain();
   endtask

   task automatic test_acc();
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b1);
      checks++; if (acc_fflags_o !== 5'd0) begin errors++; $display("FAIL acc_clear got %h want 0", acc_fflags_o); end
      drive_cycle(1'b1, RW'(9'h061), 5'h01, 1'b0, 1'b0);
      drive_cycle(1'b1, RW'(9'h062), 5'h04, 1'b0, 1'b0);
      drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
      drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
      checks++; if (acc_fflags_o !== exp_acc(5'h05)) begin errors++; $display("FAIL acc_or got %h want %h", acc_fflags_o, exp_acc(5'h05)); end
      drive_cycle(1'b1, RW'(9'h063), 5'h04, 1'b0, 1'b0);
      drive_cycle(1'b0, '0, '0, 1'b1, 1'b1);
      checks++; if (acc_fflags_o !== exp_acc(5'h04)) begin errors++; $display("FAIL acc_clr_pop got %h want %h", acc_fflags_o, exp_acc(5'h04)); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         drive_cycle(1'($urandom_range(0, 3) != 0), RW'($urandom), 5'($urandom),
                     1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
         checks++;
         if (out_valid_o !== (q.size() != 0) || in_ready_o !== (q.size() < FD) || count_o !== CNTW'(q.size())
             || acc_fflags_o !== exp_acc(m_acc) || (q.size() != 0 && dut_head() !== q[0])) begin
            errors++;
            $display("FAIL random[%0d] got v=%0b r=%0b c=%0d acc=%h head=%h want v=%0b r=%0b c=%0d acc=%h head=%h",
                     n, out_valid_o, in_ready_o, count_o, acc_fflags_o, dut_head(),
                     q.size() != 0, q.size() < FD, q.size(), exp_acc(m_acc), (q.size() != 0) ? q[0] : '0);
         end
      end
      drain();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, RW'(9'h070 + i), 5'($urandom), 1'b0, 1'b0);
      checks++; if (count_o !== CNTW'(3)) begin errors++; $display("FAIL mid_pre_count got %0d want 3", count_o); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid_o !== 1'b0 || count_o !== '0 || in_ready_o !== 1'b1 || dut_head() !== '0) begin
         errors++; $display("FAIL mid_reset got v=%0b c=%0d r=%0b head=%h want v=0 c=0 r=1 head=0",
                            out_valid_o, count_o, in_ready_o, dut_head());
      end
      q.delete();
      m_acc = '0;
      @(negedge clk);
      rst_n = 1'b1;
      drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
      checks++; if (out_valid_o !== 1'b0 || count_o !== '0) begin
         errors++; $display("FAIL mid_stale got v=%0b c=%0d want v=0 c=0", out_valid_o, count_o);
      end
      drive_cycle(1'b1, RW'(9'h055), 5'($urandom), 1'b0, 1'b0);
      checks++; if (result_o !== RW'(9'h055) || count_o !== CNTW'(1)) begin
         errors++; $display("FAIL mid_after got %h c=%0d want 055 c=1", result_o, count_o);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_full_stream();
      test_simul();
      test_acc();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
